// File: rtl/gearbox_fifo_if.sv
// gearbox_fifo_if: valid/ready handshake bundle for both sides of the width-converting FIFO.
//  in_valid/in_ready/in_data    : producer side, IN_WIDTH-bit words
//  out_valid/out_ready/out_data : consumer side, OUT_WIDTH-bit words
//  master: the environment driving the FIFO; slave: the FIFO itself
interface gearbox_fifo_if #(
    parameter int IN_WIDTH  = 64,
    parameter int OUT_WIDTH = 16
);
    logic                 in_valid;
    logic                 in_ready;
    logic [IN_WIDTH-1:0]  in_data;
    logic                 out_valid;
    logic                 out_ready;
    logic [OUT_WIDTH-1:0] out_data;
    modport master (output in_valid, in_data, out_ready, input in_ready, out_valid, out_data);
    modport slave  (input in_valid, in_data, out_ready, output in_ready, out_valid, out_data);
endinterface

// File: rtl/gearbox_fifo.sv
// gearbox_fifo: synchronous width-converting FIFO with lane-granular storage and exact lane occupancy.
//  clk, rst      : rising-edge clock, synchronous active-high reset
//  flush         : synchronous clear of contents, same effect as rst on state
//  bus           : handshake bundle (in_valid/in_ready/in_data, out_valid/out_ready/out_data)
//  count         : occupancy in lanes, 0..2**ADDR_WIDTH
//  almost_empty  : count <= AE_LEVEL
//  almost_full   : free lanes <= AF_LEVEL
module gearbox_fifo #(
    parameter int IN_WIDTH   = 64,
    parameter int OUT_WIDTH  = 16,
    parameter int ADDR_WIDTH = 4,
    parameter int MSB_FIRST  = 0,
    parameter int AE_LEVEL   = 1,
    parameter int AF_LEVEL   = 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                flush,
    gearbox_fifo_if.slave       bus,
    output logic [ADDR_WIDTH:0] count,
    output logic                almost_empty,
    output logic                almost_full
);
    localparam int LANE      = IN_WIDTH < OUT_WIDTH ? IN_WIDTH : OUT_WIDTH;
    localparam int IN_LANES  = IN_WIDTH / LANE;
    localparam int OUT_LANES = OUT_WIDTH / LANE;
    localparam int DEPTH     = 2 ** ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0] DEPTH_C = (ADDR_WIDTH+1)'(DEPTH);
    localparam logic [ADDR_WIDTH:0] IN_C    = (ADDR_WIDTH+1)'(IN_LANES);
    localparam logic [ADDR_WIDTH:0] OUT_C   = (ADDR_WIDTH+1)'(OUT_LANES);
    localparam logic [ADDR_WIDTH:0] AE_C    = (ADDR_WIDTH+1)'(AE_LEVEL);
    localparam logic [ADDR_WIDTH:0] AF_C    = (ADDR_WIDTH+1)'(AF_LEVEL);

    logic [LANE-1:0]      mem [DEPTH];
    logic [ADDR_WIDTH:0]  wr_ptr, rd_ptr, free;
    logic [OUT_WIDTH-1:0] out_word;
    logic                 push, pop;

    // Pointers carry an extra wrap bit, so the difference is the exact lane count even when full.
    assign count        = wr_ptr - rd_ptr;
    assign free         = DEPTH_C - count;
    assign bus.in_ready  = free >= IN_C;
    assign bus.out_valid = count >= OUT_C;
    assign push         = bus.in_valid & bus.in_ready;
    assign pop          = bus.out_valid & bus.out_ready;
    assign almost_empty = count <= AE_C;
    assign almost_full  = free <= AF_C;

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + IN_C;
            if (pop) rd_ptr <= rd_ptr + OUT_C;
        end
    end

    // Stream lane i lands at wr_ptr+i; lane addresses wrap naturally in ADDR_WIDTH bits,
    // so a word may straddle the end of the array. Storage is deliberately not reset.
    always_ff @(posedge clk) begin
        if (push)
            for (int i = 0; i < IN_LANES; i++)
                mem[wr_ptr[ADDR_WIDTH-1:0] + ADDR_WIDTH'(i)] <=
                    bus.in_data[LANE*(MSB_FIRST != 0 ? IN_LANES-1-i : i) +: LANE];
    end

    always_comb begin
        out_word = '0;
        for (int j = 0; j < OUT_LANES; j++)
            out_word[LANE*(MSB_FIRST != 0 ? OUT_LANES-1-j : j) +: LANE] =
                mem[rd_ptr[ADDR_WIDTH-1:0] + ADDR_WIDTH'(j)];
    end

    // Masking keeps never-written storage from showing on the output while nothing is valid.
    assign bus.out_data = bus.out_valid ? out_word : '0;
endmodule

// File: tb/tb_gearbox_fifo.sv
// tb_gearbox_fifo: directed vector table plus scoreboarded random traffic over four gearbox_fifo configurations.
//  dut_a: 64->16 lsb-first, dut_b: 16->64 lsb-first, dut_c: 16->64 msb-first, dut_d: 32->16 with 8 lanes
module tb_gearbox_fifo;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] fl = '0;
    logic [3:0] ae, af;
    logic [4:0] cnt_a, cnt_b, cnt_c;
    logic [3:0] cnt_d;
    int         tests = 0;
    int         fails = 0;

    always #5 clk = ~clk;

    gearbox_fifo_if #(.IN_WIDTH(64), .OUT_WIDTH(16)) if_a ();
    gearbox_fifo_if #(.IN_WIDTH(16), .OUT_WIDTH(64)) if_b ();
    gearbox_fifo_if #(.IN_WIDTH(16), .OUT_WIDTH(64)) if_c ();
    gearbox_fifo_if #(.IN_WIDTH(32), .OUT_WIDTH(16)) if_d ();

    gearbox_fifo #(.IN_WIDTH(64), .OUT_WIDTH(16), .ADDR_WIDTH(4), .MSB_FIRST(0)) dut_a (
        .clk(clk), .rst(rst), .flush(fl[0]), .bus(if_a), .count(cnt_a), .almost_empty(ae[0]), .almost_full(af[0]));
    gearbox_fifo #(.IN_WIDTH(16), .OUT_WIDTH(64), .ADDR_WIDTH(4), .MSB_FIRST(0)) dut_b (
        .clk(clk), .rst(rst), .flush(fl[1]), .bus(if_b), .count(cnt_b), .almost_empty(ae[1]), .almost_full(af[1]));
    gearbox_fifo #(.IN_WIDTH(16), .OUT_WIDTH(64), .ADDR_WIDTH(4), .MSB_FIRST(1)) dut_c (
        .clk(clk), .rst(rst), .flush(fl[2]), .bus(if_c), .count(cnt_c), .almost_empty(ae[2]), .almost_full(af[2]));
    gearbox_fifo #(.IN_WIDTH(32), .OUT_WIDTH(16), .ADDR_WIDTH(3), .MSB_FIRST(0)) dut_d (
        .clk(clk), .rst(rst), .flush(fl[3]), .bus(if_d), .count(cnt_d), .almost_empty(ae[3]), .almost_full(af[3]));

    typedef struct {
        int          sel;
        logic        fl, iv;
        logic [63:0] din;
        logic        ordy;
        logic        ir, ov;
        logic [63:0] dout;
        int          cnt;
        logic        ae, af;
    } vec_t;

    vec_t v[$];

    function automatic void add(int sel, logic f, iv, logic [63:0] d, logic ordy,
                                logic ir, ov, logic [63:0] od, int cnt, logic e, a);
        vec_t t = '{sel, f, iv, d, ordy, ir, ov, od, cnt, e, a};
        v.push_back(t);
    endfunction

    function automatic logic [63:0] w4(logic [15:0] b);
        return {16'(b + 16'd3), 16'(b + 16'd2), 16'(b + 16'd1), b};
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic idle();
        fl = '0;
        if_a.in_valid = 0; if_a.out_ready = 0; if_a.in_data = '0;
        if_b.in_valid = 0; if_b.out_ready = 0; if_b.in_data = '0;
        if_c.in_valid = 0; if_c.out_ready = 0; if_c.in_data = '0;
        if_d.in_valid = 0; if_d.out_ready = 0; if_d.in_data = '0;
    endtask

    task automatic drive(input int sel, input logic f, iv, input logic [63:0] d, input logic ordy);
        idle();
        fl[sel] = f;
        case (sel)
            0: begin if_a.in_valid = iv; if_a.in_data = d;        if_a.out_ready = ordy; end
            1: begin if_b.in_valid = iv; if_b.in_data = d[15:0];  if_b.out_ready = ordy; end
            2: begin if_c.in_valid = iv; if_c.in_data = d[15:0];  if_c.out_ready = ordy; end
            default: begin if_d.in_valid = iv; if_d.in_data = d[31:0]; if_d.out_ready = ordy; end
        endcase
    endtask

    task automatic sample(input int sel, output logic ir, ov, output logic [63:0] od,
                          output int cnt, output logic e, a);
        case (sel)
            0: begin ir = if_a.in_ready; ov = if_a.out_valid; od = 64'(if_a.out_data); cnt = int'(cnt_a); end
            1: begin ir = if_b.in_ready; ov = if_b.out_valid; od = if_b.out_data;      cnt = int'(cnt_b); end
            2: begin ir = if_c.in_ready; ov = if_c.out_valid; od = if_c.out_data;      cnt = int'(cnt_c); end
            default: begin ir = if_d.in_ready; ov = if_d.out_valid; od = 64'(if_d.out_data); cnt = int'(cnt_d); end
        endcase
        e = ae[sel];
        a = af[sel];
    endtask

    initial begin
        logic        s_ir, s_ov, s_ae, s_af;
        logic [63:0] s_od;
        int          s_cnt;
        logic        a_iv, a_or, a_ir, a_ov, b_iv, b_or, b_ir, b_ov;
        logic [63:0] a_d;
        logic [15:0] b_d;
        logic [15:0] qa[$], qb[$];
        int          p;

        // 64->16 basic split
        add(0, 0, 1, 64'h4444_3333_2222_1111, 1, 1, 0, 0, 0, 1, 0);
        add(0, 0, 0, 0, 1, 1, 1, 'h1111, 4, 0, 0);
        add(0, 0, 0, 0, 1, 1, 1, 'h2222, 3, 0, 0);
        add(0, 0, 0, 0, 1, 1, 1, 'h3333, 2, 0, 0);
        add(0, 0, 0, 0, 1, 1, 1, 'h4444, 1, 1, 0);
        add(0, 0, 0, 0, 1, 1, 0, 0, 0, 1, 0);
        // 64->16 fill to full, fifth word refused, then drain in order
        add(0, 0, 1, w4(16'h0100), 0, 1, 0, 0, 0, 1, 0);
        for (int k = 1; k < 4; k++) add(0, 0, 1, w4(16'(16'h0100 + 4*k)), 0, 1, 1, 'h0100, 4*k, 0, 0);
        add(0, 0, 1, 64'hDEAD_BEEF_DEAD_BEEF, 0, 0, 1, 'h0100, 16, 0, 1);
        add(0, 0, 0, 0, 0, 0, 1, 'h0100, 16, 0, 1);
        for (int k = 0; k < 16; k++) add(0, 0, 0, 0, 1, k >= 4, 1, 64'('h0100 + k), 16 - k, k == 15, k <= 1);
        add(0, 0, 0, 0, 0, 1, 0, 0, 0, 1, 0);
        // 64->16 flush mid-stream at count 10 with a concurrent push
        add(0, 0, 1, w4(16'h0A00), 0, 1, 0, 0, 0, 1, 0);
        add(0, 0, 1, w4(16'h0A04), 0, 1, 1, 'h0A00, 4, 0, 0);
        add(0, 0, 1, w4(16'h0A08), 0, 1, 1, 'h0A00, 8, 0, 0);
        add(0, 0, 0, 0, 1, 1, 1, 'h0A00, 12, 0, 0);
        add(0, 0, 0, 0, 1, 1, 1, 'h0A01, 11, 0, 0);
        add(0, 1, 1, 64'hFFFF_FFFF_FFFF_FFFF, 0, 1, 1, 'h0A02, 10, 0, 0);
        add(0, 0, 1, w4(16'h0B00), 1, 1, 0, 0, 0, 1, 0);
        add(0, 0, 0, 0, 1, 1, 1, 'h0B00, 4, 0, 0);
        add(0, 0, 0, 0, 1, 1, 1, 'h0B01, 3, 0, 0);
        add(0, 0, 0, 0, 1, 1, 1, 'h0B02, 2, 0, 0);
        add(0, 0, 0, 0, 1, 1, 1, 'h0B03, 1, 1, 0);
        add(0, 0, 0, 0, 1, 1, 0, 0, 0, 1, 0);
        // 16->64 gather, lsb-first then msb-first
        for (int s = 1; s < 3; s++) begin
            add(s, 0, 1, 'hAAAA, 1, 1, 0, 0, 0, 1, 0);
            add(s, 0, 1, 'hBBBB, 1, 1, 0, 0, 1, 1, 0);
            add(s, 0, 1, 'hCCCC, 1, 1, 0, 0, 2, 0, 0);
            add(s, 0, 1, 'hDDDD, 1, 1, 0, 0, 3, 0, 0);
            add(s, 0, 0, 0, 1, 1, 1, s == 1 ? 64'hDDDD_CCCC_BBBB_AAAA : 64'hAAAA_BBBB_CCCC_DDDD, 4, 0, 0);
            add(s, 0, 0, 0, 1, 1, 0, 0, 0, 1, 0);
        end
        // 32->16 in 8 lanes: walk pointers to 6, then words across the wrap point
        add(3, 0, 1, 'h0001_0000, 1, 1, 0, 0, 0, 1, 0);
        add(3, 0, 1, 'h0003_0002, 1, 1, 1, 'h0000, 2, 0, 0);
        add(3, 0, 1, 'h0005_0004, 1, 1, 1, 'h0001, 3, 0, 0);
        add(3, 0, 0, 0, 1, 1, 1, 'h0002, 4, 0, 0);
        add(3, 0, 0, 0, 1, 1, 1, 'h0003, 3, 0, 0);
        add(3, 0, 0, 0, 1, 1, 1, 'h0004, 2, 0, 0);
        add(3, 0, 0, 0, 1, 1, 1, 'h0005, 1, 1, 0);
        add(3, 0, 1, 'h2222_1111, 0, 1, 0, 0, 0, 1, 0);
        add(3, 0, 1, 'h4444_3333, 0, 1, 1, 'h1111, 2, 0, 0);
        add(3, 0, 0, 0, 1, 1, 1, 'h1111, 4, 0, 0);
        add(3, 0, 0, 0, 1, 1, 1, 'h2222, 3, 0, 0);
        add(3, 0, 0, 0, 1, 1, 1, 'h3333, 2, 0, 0);
        add(3, 0, 0, 0, 1, 1, 1, 'h4444, 1, 1, 0);
        add(3, 0, 0, 0, 1, 1, 0, 0, 0, 1, 0);

        idle();
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        for (int s = 0; s < 4; s++) begin
            sample(s, s_ir, s_ov, s_od, s_cnt, s_ae, s_af);
            chk($sformatf("rst%0d.in_ready", s), 64'(s_ir), 1);
            chk($sformatf("rst%0d.out_valid", s), 64'(s_ov), 0);
            chk($sformatf("rst%0d.count", s), 64'(s_cnt), 0);
            chk($sformatf("rst%0d.almost_empty", s), 64'(s_ae), 1);
            chk($sformatf("rst%0d.almost_full", s), 64'(s_af), 0);
        end

        foreach (v[k]) begin
            @(negedge clk);
            drive(v[k].sel, v[k].fl, v[k].iv, v[k].din, v[k].ordy);
            #1;
            sample(v[k].sel, s_ir, s_ov, s_od, s_cnt, s_ae, s_af);
            chk($sformatf("v%0d.in_ready", k), 64'(s_ir), 64'(v[k].ir));
            chk($sformatf("v%0d.out_valid", k), 64'(s_ov), 64'(v[k].ov));
            chk($sformatf("v%0d.count", k), 64'(s_cnt), 64'(v[k].cnt));
            chk($sformatf("v%0d.almost_empty", k), 64'(s_ae), 64'(v[k].ae));
            chk($sformatf("v%0d.almost_full", k), 64'(s_af), 64'(v[k].af));
            if (v[k].ov) chk($sformatf("v%0d.out_data", k), s_od, v[k].dout);
        end

        // Random traffic on dut_a and dut_b against a lane-stream scoreboard,
        // alternating fill-biased and drain-biased phases to hit full, empty and wrap.
        @(negedge clk);
        idle();
        for (int c = 0; c < 8000; c++) begin
            @(negedge clk);
            p = ((c / 500) % 2 == 1) ? 80 : 20;
            a_iv = $urandom_range(0, 99) < p;
            a_or = $urandom_range(0, 99) >= p;
            a_d  = {$urandom, $urandom};
            b_iv = $urandom_range(0, 99) < p;
            b_or = $urandom_range(0, 99) >= p;
            b_d  = 16'($urandom);
            if_a.in_valid = a_iv; if_a.in_data = a_d; if_a.out_ready = a_or;
            if_b.in_valid = b_iv; if_b.in_data = b_d; if_b.out_ready = b_or;
            #1;
            a_ir = (16 - qa.size()) >= 4;
            a_ov = qa.size() >= 1;
            b_ir = (16 - qb.size()) >= 1;
            b_ov = qb.size() >= 4;
            chk("rnd_a.in_ready", 64'(if_a.in_ready), 64'(a_ir));
            chk("rnd_a.out_valid", 64'(if_a.out_valid), 64'(a_ov));
            chk("rnd_a.count", 64'(cnt_a), 64'(qa.size()));
            if (a_ov) chk("rnd_a.out_data", 64'(if_a.out_data), 64'(qa[0]));
            chk("rnd_b.in_ready", 64'(if_b.in_ready), 64'(b_ir));
            chk("rnd_b.out_valid", 64'(if_b.out_valid), 64'(b_ov));
            chk("rnd_b.count", 64'(cnt_b), 64'(qb.size()));
            if (b_ov) chk("rnd_b.out_data", if_b.out_data, {qb[3], qb[2], qb[1], qb[0]});
            if (a_or && a_ov) void'(qa.pop_front());
            if (a_iv && a_ir) for (int i = 0; i < 4; i++) qa.push_back(a_d[16*i +: 16]);
            if (b_or && b_ov) repeat (4) void'(qb.pop_front());
            if (b_iv && b_ir) qb.push_back(b_d);
        end
        @(negedge clk);
        idle();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
